// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field bounds, HALT opcode
// and the fetch state encoding.
package cpu_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int ADDR_WIDTH        = 9;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int DEST_MSB   = 26;
    localparam int DEST_LSB   = 18;
    localparam int SRC1_MSB   = 17;
    localparam int SRC1_LSB   = 9;
    localparam int SRC2_MSB   = 8;
    localparam int SRC2_LSB   = 0;

    localparam logic [OPCODE_MSB-OPCODE_LSB:0] OP_HALT = 5'b11111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [OPCODE_MSB-OPCODE_LSB:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {word, pc} entries; flush beats push, and the
// head reads as zero while empty.
module fetch_fifo #(
    parameter int  WIDTH = 41,
    parameter int  DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        do_push  = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency reads to program memory,
// buffers returned words for the decoder, handles redirect/flush and HALT.
module instr_fetch_unit
    import cpu_pkg::fetch_state_t, cpu_pkg::RUN, cpu_pkg::HALTED,
           cpu_pkg::OPCODE_MSB, cpu_pkg::OPCODE_LSB, cpu_pkg::is_halt;
#(
    parameter int                    INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
    parameter int                    ADDR_WIDTH        = cpu_pkg::ADDR_WIDTH,
    parameter int                    FIFO_DEPTH        = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_en,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]        instr_pc,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         halted
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = INSTRUCTION_WIDTH + ADDR_WIDTH;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit_used;
    logic [ENTRY_W-1:0]    head_data;
    logic                  halt_seen;
    logic                  issue;
    logic                  push;
    logic                  pop;

    assign halt_seen   = inflight_q && is_halt(imem_rdata[OPCODE_MSB:OPCODE_LSB]);
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

    // rst_n gates the request so memory sees no read while reset is held.
    assign issue = rst_n && (state_q == RUN) && !redirect_valid && !halt_seen &&
                   (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    assign push = inflight_q && !redirect_valid;
    assign pop  = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (issue) begin
            pc_d     = pc_q + ADDR_WIDTH'(1);
            req_pc_d = pc_q;
        end
        if (push && halt_seen) state_d = HALTED;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_data_i  ({imem_rdata, req_pc_q}),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (fifo_count),
        .head_valid_o (instr_valid),
        .head_data_o  (head_data)
    );

    assign {instruction, instr_pc} = head_data;
    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: per-cycle vector table after reset plus
// hand-written backpressure, redirect, HALT, wrap and async-reset sequences.
module tb_instr_fetch_unit;

    localparam int IW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_en, w_imem_en;
    logic [AW-1:0] imem_addr, w_imem_addr;
    logic [IW-1:0] imem_rdata, w_imem_rdata;
    logic          instr_valid, w_instr_valid;
    logic          instr_ready;
    logic          w_instr_ready;
    logic [IW-1:0] instruction, w_instruction;
    logic [AW-1:0] instr_pc, w_instr_pc;
    logic          redirect_valid, w_redirect_valid;
    logic [AW-1:0] redirect_pc, w_redirect_pc;
    logic          halted, w_halted;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    instr_fetch_unit #(.RESET_PC(9'h1FE)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (w_imem_en),
        .imem_addr      (w_imem_addr),
        .imem_rdata     (w_imem_rdata),
        .instr_valid    (w_instr_valid),
        .instr_ready    (w_instr_ready),
        .instruction    (w_instruction),
        .instr_pc       (w_instr_pc),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .halted         (w_halted)
    );

    // Program memory model: one-cycle synchronous read.
    logic [IW-1:0] mem [0:511];
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr];
        if (w_imem_en) w_imem_rdata <= mem[w_imem_addr];
    end

    typedef struct packed {
        logic [IW-1:0] word;
        logic [AW-1:0] pc;
    } exp_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic          valid;
        logic [AW-1:0] pc;
        logic          w_valid;
        logic [AW-1:0] w_pc;
    } vec_t;

    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [6];
    int   n_pass   = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = start + AW'(k);
            sb.push_back('{word: mem[a], pc: a});
        end
    endtask

    // Scoreboard monitor: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            check("pop_has_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pop_pc", instr_pc, mon_e.pc);
                check("pop_word", instruction, mon_e.word);
            end
        end
    end

    initial begin
        int            en_cnt;
        logic [AW-1:0] held_pc;

        vecs[0] = '{1'b1, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000};
        vecs[1] = '{1'b1, 9'h001, 1'b0, 9'h000, 1'b0, 9'h000};
        vecs[2] = '{1'b1, 9'h002, 1'b1, 9'h000, 1'b1, 9'h1FE};
        vecs[3] = '{1'b1, 9'h003, 1'b1, 9'h001, 1'b1, 9'h1FF};
        vecs[4] = '{1'b1, 9'h004, 1'b1, 9'h002, 1'b1, 9'h000};
        vecs[5] = '{1'b1, 9'h005, 1'b1, 9'h003, 1'b1, 9'h001};

        for (int i = 0; i < 512; i++) mem[i] = IW'(i);
        rst_n            = 1'b0;
        instr_ready      = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        w_instr_ready    = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        imem_rdata       = '0;
        w_imem_rdata     = '0;
        push_range(9'h000, 64);

        // Reset state
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_imem_en", imem_en, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instruction", instruction, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_addr", imem_addr, 9'h000);
        check("rst_wrap_imem_addr", w_imem_addr, 9'h1FE);

        // Free run from reset, including the wrapping instance
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("c%0d_imem_en", i), imem_en, vecs[i].en);
            check($sformatf("c%0d_imem_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("c%0d_valid", i), instr_valid, vecs[i].valid);
            check($sformatf("c%0d_pc", i), instr_pc, vecs[i].pc);
            check($sformatf("c%0d_wrap_valid", i), w_instr_valid, vecs[i].w_valid);
            check($sformatf("c%0d_wrap_pc", i), w_instr_pc, vecs[i].w_pc);
            next_cycle();
        end

        // Backpressure: 10 cycles of instr_ready low
        next_cycle();
        instr_ready = 1'b0;
        en_cnt      = 0;
        held_pc     = '0;
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            en_cnt += int'(imem_en);
            if (h == 4) held_pc = instr_pc;
            if (h == 9) begin
                check("bp_imem_en_low", imem_en, 0);
                check("bp_valid_held", instr_valid, 1);
                check("bp_head_stable", instr_pc, held_pc);
            end
            next_cycle();
        end
        check("bp_issue_cycles", en_cnt, 1);
        instr_ready = 1'b1;
        repeat (6) next_cycle();

        // Redirect to 0x100 during streaming
        redirect_valid = 1'b1;
        redirect_pc    = 9'h100;
        next_cycle();
        redirect_valid = 1'b0;
        sb.delete();
        push_range(9'h100, 16);
        @(negedge clk);
        check("rd_t1_valid", instr_valid, 0);
        check("rd_t1_imem_en", imem_en, 1);
        check("rd_t1_imem_addr", imem_addr, 9'h100);
        next_cycle();
        @(negedge clk);
        check("rd_t2_valid", instr_valid, 0);
        next_cycle();
        @(negedge clk);
        check("rd_t3_valid", instr_valid, 1);
        check("rd_t3_pc", instr_pc, 9'h100);
        repeat (5) next_cycle();

        // HALT at address 5
        rst_n  = 1'b0;
        mem[5] = 32'hF800_0000;
        sb.delete();
        push_range(9'h000, 6);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 5) begin
                check("halt_c5_imem_en", imem_en, 1);
                check("halt_c5_imem_addr", imem_addr, 9'h005);
            end
            if (c == 6) begin
                check("halt_c6_imem_en", imem_en, 0);
                check("halt_c6_halted", halted, 0);
            end
            if (c == 7) begin
                check("halt_c7_halted", halted, 1);
                check("halt_c7_valid", instr_valid, 1);
                check("halt_c7_pc", instr_pc, 9'h005);
            end
            next_cycle();
        end
        repeat (5) next_cycle();
        @(negedge clk);
        check("halt_stays_halted", halted, 1);
        check("halt_no_issue", imem_en, 0);
        check("halt_fifo_empty", instr_valid, 0);
        check("halt_all_delivered", sb.size(), 0);

        // Redirect out of HALTED
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 9'h000;
        @(negedge clk);
        check("halt_rd_t0_halted", halted, 1);
        next_cycle();
        redirect_valid = 1'b0;
        push_range(9'h000, 6);
        @(negedge clk);
        check("halt_rd_t1_halted", halted, 0);
        check("halt_rd_t1_imem_en", imem_en, 1);
        check("halt_rd_t1_imem_addr", imem_addr, 9'h000);
        repeat (12) next_cycle();
        @(negedge clk);
        check("halt_rd_all_delivered", sb.size(), 0);
        check("halt_rd_halted_again", halted, 1);
        mem[5] = 32'h0000_0005;

        // Async reset with the FIFO full
        next_cycle();
        rst_n = 1'b0;
        sb.delete();
        push_range(9'h000, 64);
        next_cycle();
        rst_n = 1'b1;
        repeat (4) next_cycle();
        instr_ready = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        check("ar_full_valid", instr_valid, 1);
        check("ar_full_imem_en", imem_en, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_dropped", instr_valid, 0);
        check("ar_imem_en_dropped", imem_en, 0);
        check("ar_instruction_zero", instruction, 0);
        check("ar_instr_pc_zero", instr_pc, 0);
        sb.delete();
        push_range(9'h000, 64);
        instr_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_c0_imem_en", imem_en, 1);
        check("ar_c0_imem_addr", imem_addr, 9'h000);
        check("ar_c0_valid", instr_valid, 0);
        repeat (14) next_cycle();
        instr_ready = 1'b0;
        @(negedge clk);
        check("ar_throughput_pops", sb.size(), 52);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
